// File: rtl/cpu_nios_display_mux_pkg.sv
// -----------------------------------------------------------------------------
// cpu_nios_display_mux_pkg
// Shared constants for the Nios display multiplexer:
//   - register word addresses
//   - CTRL bit positions, writable-bit mask and reset value
//   - active-low 7-segment lookup for hex digits 0..F
// -----------------------------------------------------------------------------
package cpu_nios_display_mux_pkg;

  // Register word addresses.
  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_DP     = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;

  // CTRL layout: bit0 enable, bit1 blink_en, bits 7:4 per-digit blank mask.
  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_BLINK_BIT = 1;
  localparam int unsigned CTRL_BLANK_LSB = 4;
  localparam logic [7:0]  CTRL_MASK      = 8'hF3;
  localparam logic [7:0]  CTRL_RESET     = 8'h01;

  // All segments off, active-low.
  localparam logic [6:0] SEG_DARK = 7'h7F;

  // Active-low segment patterns {g,f,e,d,c,b,a}; entry i is hex digit i.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,  // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,  // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,  // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40   // 3 2 1 0
  };

endpackage

// File: rtl/cpu_nios_display_mux_hex7seg.sv
// -----------------------------------------------------------------------------
// cpu_nios_hex7seg
// Combinational hex digit to active-low 7-segment decoder.
// Ports:
//   hex    in  4  hex digit 0..F
//   seg_n  out 7  segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module cpu_nios_hex7seg
  import cpu_nios_display_mux_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_LUT[hex];

endmodule

// File: rtl/cpu_nios_display_mux.sv
// -----------------------------------------------------------------------------
// cpu_nios_display_mux
// Avalon-MM slave that holds four hex digits, decimal points and control bits
// written by the Nios CPU, and time-multiplexes them onto a 4-digit
// common-anode 7-segment display with per-digit blanking and whole-display
// blink.
// Ports:
//   clk         in  1   system clock
//   reset_n     in  1   asynchronous active-low reset
//   address     in  3   word address (0 DATA, 1 DP, 2 CTRL, 3 STATUS)
//   chipselect  in  1   slave select
//   write_n     in  1   active-low write strobe
//   writedata   in  32  write data
//   readdata    out 32  registered read data (1-cycle latency)
//   seg_n       out 7   segments {g,f,e,d,c,b,a}, active-low
//   dp_n        out 1   decimal point, active-low
//   an_n        out 4   digit anodes, active-low, one-hot when lit
// -----------------------------------------------------------------------------
module cpu_nios_display_mux
  import cpu_nios_display_mux_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 250
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n
);

  localparam int unsigned PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Bus handshake: there is no wait-request. A write commits on the clk edge
  // where chipselect=1 and write_n=0. readdata is re-registered every cycle
  // from the address mux (chipselect ignored), so data for an address is
  // valid one cycle after that address is presented.
  logic        wr_en;
  assign wr_en = chipselect & ~write_n;

  // Register file.
  logic [15:0] data_q;
  logic [3:0]  dp_q;
  logic [7:0]  ctrl_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= 16'h0000;
      dp_q   <= 4'h0;
      ctrl_q <= CTRL_RESET;
    end else if (wr_en) begin
      case (address)
        REG_DATA: data_q <= writedata[15:0];
        REG_DP:   dp_q   <= writedata[3:0];
        REG_CTRL: ctrl_q <= writedata[7:0] & CTRL_MASK;
        default:  ;  // STATUS and reserved words are not writable
      endcase
    end
  end

  // Upper write-data bits have no storage behind them.
  logic unused_wdata;
  assign unused_wdata = ^writedata[31:16];

  logic       ctrl_en;
  logic       ctrl_blink;
  logic [3:0] ctrl_blank;
  assign ctrl_en    = ctrl_q[CTRL_EN_BIT];
  assign ctrl_blink = ctrl_q[CTRL_BLINK_BIT];
  assign ctrl_blank = ctrl_q[CTRL_BLANK_LSB +: 4];

  // Prescaler, scan index and blink timebase. These free-run regardless of
  // enable so the blink phase and scan position stay observable in STATUS.
  logic [PW-1:0] presc_q;
  logic          tick;
  logic [1:0]    scan_idx_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;

  assign tick = (presc_q == PW'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q       <= '0;
      scan_idx_q    <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        scan_idx_q <= scan_idx_q + 2'd1;
        if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
          blink_cnt_q   <= '0;
          blink_phase_q <= ~blink_phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 1'b1;
        end
      end
    end
  end

  // Read mux.
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = 32'h0;
    case (address)
      REG_DATA:   rd_mux = {16'h0, data_q};
      REG_DP:     rd_mux = {28'h0, dp_q};
      REG_CTRL:   rd_mux = {24'h0, ctrl_q};
      REG_STATUS: rd_mux = {29'h0, scan_idx_q, blink_phase_q};
      default:    rd_mux = 32'h0;
    endcase
  end

  // Digit selection and decode for the currently scanned position.
  logic [3:0] cur_digit;
  logic [6:0] cur_seg_n;
  logic       dark;

  assign cur_digit = data_q[{scan_idx_q, 2'b00} +: 4];
  assign dark      = ~ctrl_en | ctrl_blank[scan_idx_q]
                   | (ctrl_blink & blink_phase_q);

  cpu_nios_hex7seg u_hex7seg (
    .hex   (cur_digit),
    .seg_n (cur_seg_n)
  );

  // Registered outputs: they follow register and scan state one cycle later,
  // so a write and a scan step on the same edge show up together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'h0;
      an_n     <= 4'hF;
      seg_n    <= SEG_DARK;
      dp_n     <= 1'b1;
    end else begin
      readdata <= rd_mux;
      if (dark) begin
        an_n  <= 4'hF;
        seg_n <= SEG_DARK;
        dp_n  <= 1'b1;
      end else begin
        an_n  <= ~(4'b0001 << scan_idx_q);
        seg_n <= cur_seg_n;
        dp_n  <= ~dp_q[scan_idx_q];
      end
    end
  end

endmodule

// File: tb/tb_cpu_nios_display_mux.sv
// -----------------------------------------------------------------------------
// tb_cpu_nios_display_mux
// Directed bench for cpu_nios_display_mux with SCAN_DIV=4, BLINK_DIV=2.
// The expected output after clk edge k (k counted from reset release) is
// derived from a register-level model plus closed-form timing:
//   scan_idx before edge k    = (k / SCAN_DIV) % 4
//   blink_phase before edge k = (k / (SCAN_DIV*BLINK_DIV)) % 2
// -----------------------------------------------------------------------------
module tb_cpu_nios_display_mux;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;

  // Clock / reset.
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;

  always #5 clk = ~clk;

  cpu_nios_display_mux #(
    .SCAN_DIV  (SCAN_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n)
  );

  // Scoreboard: {readdata, an_n, seg_n, dp_n}.
  localparam int OW = 44;
  localparam logic [OW-1:0] RESET_OUT = {32'h0, 4'hF, 7'h7F, 1'b1};

  logic [OW-1:0] exp_q[$];
  int            tests_run = 0;
  int            fails     = 0;

  // Model state.
  int          k;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic        m_en;
  logic        m_blink;
  logic [3:0]  m_blank;
  logic [2:0]  rd_addr;

  logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  function automatic logic [OW-1:0] model_out();
    int          idx;
    logic        ph;
    logic [31:0] rd;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    idx = (k / SCAN_DIV) % 4;
    ph  = ((k / (SCAN_DIV * BLINK_DIV)) % 2) == 1;
    case (address)
      3'd0:    rd = {16'h0, m_data};
      3'd1:    rd = {28'h0, m_dp};
      3'd2:    rd = {24'h0, m_blank, 2'b00, m_blink, m_en};
      3'd3:    rd = {29'h0, 2'(idx), ph};
      default: rd = 32'h0;
    endcase
    if (!m_en || m_blank[idx] || (m_blink && ph)) begin
      an  = 4'hF;
      seg = 7'h7F;
      dp  = 1'b1;
    end else begin
      an  = ~(4'b0001 << idx);
      seg = seg_lut[m_data[idx*4 +: 4]];
      dp  = ~m_dp[idx];
    end
    return {rd, an, seg, dp};
  endfunction

  task automatic model_write();
    if (chipselect && !write_n) begin
      case (address)
        3'd0: m_data = writedata[15:0];
        3'd1: m_dp   = writedata[3:0];
        3'd2: begin
          m_en    = writedata[0];
          m_blink = writedata[1];
          m_blank = writedata[7:4];
        end
        default: ;
      endcase
    end
  endtask

  task automatic model_reset();
    k       = 0;
    m_data  = 16'h0;
    m_dp    = 4'h0;
    m_en    = 1'b1;
    m_blink = 1'b0;
    m_blank = 4'h0;
    exp_q.delete();
  endtask

  // One clock: push expectation at the edge, compare on the falling edge.
  task automatic cyc(input int n);
    logic [OW-1:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (reset_n) begin
        exp_q.push_back(model_out());
        model_write();
        k++;
      end
      @(negedge clk);
      if (reset_n) begin
        chk("sb_depth", OW'(exp_q.size()), OW'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out", {readdata, an_n, seg_n, dp_n}, e);
        end
      end else begin
        chk("rst_hold", {readdata, an_n, seg_n, dp_n}, RESET_OUT);
      end
    end
  endtask

  // Driver: single-cycle write, then return to the read address.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    cyc(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    address    = rd_addr;
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    rd_addr    = 3'd2;
    address    = rd_addr;
    model_reset();
    cyc(3);

    // Release; CTRL read returns 0x01, digit0 shows '0'.
    reset_n = 1'b1;
    model_reset();
    cyc(5);

    // Scan order with DATA=0x1234, DP=0x1.
    rd_addr = 3'd0;
    bus_write(3'd0, 32'h0000_1234);
    bus_write(3'd1, 32'h0000_0001);
    cyc(18);

    // Blank digit1, then disable the whole display.
    rd_addr = 3'd2;
    bus_write(3'd2, 32'h0000_0021);
    cyc(17);
    bus_write(3'd2, 32'h0000_0000);
    cyc(5);

    // Blink, watching STATUS.
    rd_addr = 3'd3;
    bus_write(3'd2, 32'h0000_0003);
    cyc(34);

    // Clear blink_en mid-phase, STATUS and reserved writes.
    bus_write(3'd2, 32'h0000_0001);
    cyc(3);
    bus_write(3'd3, 32'hFFFF_FFFF);
    cyc(3);
    rd_addr = 3'd5;
    bus_write(3'd5, 32'hFFFF_FFFF);
    cyc(3);

    // DATA write landing exactly on a tick edge.
    rd_addr = 3'd0;
    address = rd_addr;
    while ((k % SCAN_DIV) != SCAN_DIV - 1) cyc(1);
    bus_write(3'd0, 32'hFFFF_ABCD);
    cyc(20);

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_readdata", OW'(readdata), OW'(32'h0));
    chk("async_rst_an",       OW'(an_n),     OW'(4'hF));
    chk("async_rst_seg",      OW'(seg_n),    OW'(7'h7F));
    chk("async_rst_dp",       OW'(dp_n),     OW'(1'b1));
    @(negedge clk);
    cyc(2);
    reset_n = 1'b1;
    model_reset();
    rd_addr = 3'd2;
    address = rd_addr;
    cyc(10);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
